// File: rtl/dbi_tx_fsm_if.sv
// Pixel-stream and PHY request bundle between dbi_tx_fsm and its neighbours.
// The master view belongs to the sequencer. The slave view is the pixel source
// and PHY side.
interface dbi_tx_fsm_if #(
    parameter int unsigned PXL_W      = 16,
    parameter int unsigned DBI_IF_D_W = 8
);
    logic [PXL_W-1:0]      pxl_dat_i;
    logic                  pxl_vld_i;
    logic                  pxl_rdy_o;
    logic                  dtf_dbi_hrst_o;
    logic [7:0]            dtf_tx_cmd_typ_o;
    logic [DBI_IF_D_W-1:0] dtf_tx_cmd_dat_o;
    logic                  dtf_tx_no_dat_o;
    logic                  dtf_tx_last_o;
    logic                  dtf_tx_vld_o;
    logic                  dtf_tx_rdy_i;

    modport master (
        input  pxl_dat_i, pxl_vld_i, dtf_tx_rdy_i,
        output pxl_rdy_o, dtf_dbi_hrst_o, dtf_tx_cmd_typ_o, dtf_tx_cmd_dat_o,
               dtf_tx_no_dat_o, dtf_tx_last_o, dtf_tx_vld_o
    );

    modport slave (
        output pxl_dat_i, pxl_vld_i, dtf_tx_rdy_i,
        input  pxl_rdy_o, dtf_dbi_hrst_o, dtf_tx_cmd_typ_o, dtf_tx_cmd_dat_o,
               dtf_tx_no_dat_o, dtf_tx_last_o, dtf_tx_vld_o
    );
endinterface

// File: rtl/dbi_tx_fsm.sv
// DBI Type-B transmit sequencer.
// After reset it sends a hardware-reset request, then the panel init commands.
// After that, each frame request sends CASET, PASET and one RAMWR burst of pixels.
module dbi_tx_fsm #(
    parameter int unsigned DBI_IF_D_W     = 8,
    parameter int unsigned PXL_W          = 16,
    parameter int unsigned H_RES          = 320,
    parameter int unsigned V_RES          = 240,
    parameter logic [7:0]  MADCTL_VAL     = 8'h00,
    parameter logic [7:0]  COLMOD_VAL     = 8'h55,
    parameter int unsigned T_RST_WAIT_CYC = 15000000,
    parameter int unsigned T_SLP_WAIT_CYC = 15000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frm_start_i,
    dbi_tx_fsm_if.master bus,
    output logic         init_done_o,
    output logic         frm_busy_o,
    output logic         frm_done_o
);

    localparam int unsigned NPIX     = H_RES * V_RES;
    localparam int unsigned NBYTE    = NPIX * 2;
    localparam int unsigned CNT_RAW  = $clog2(NBYTE);
    // CASET/PASET need four beat indices even for tiny frames
    localparam int unsigned CNT_W    = (CNT_RAW < 2) ? 2 : CNT_RAW;
    localparam int unsigned PIX_W    = $clog2(NPIX + 1);
    localparam int unsigned WAIT_MAX = (T_RST_WAIT_CYC > T_SLP_WAIT_CYC) ?
                                       T_RST_WAIT_CYC : T_SLP_WAIT_CYC;
    localparam int unsigned WAIT_W   = $clog2(WAIT_MAX) + 1;

    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(NBYTE - 1);
    localparam logic [PIX_W-1:0]  PIX_TOTAL = PIX_W'(NPIX);
    localparam logic [WAIT_W-1:0] RST_LOAD  = WAIT_W'(T_RST_WAIT_CYC - 1);
    localparam logic [WAIT_W-1:0] SLP_LOAD  = WAIT_W'(T_SLP_WAIT_CYC - 1);
    localparam logic [15:0]       COL_END   = 16'(H_RES - 1);
    localparam logic [15:0]       ROW_END   = 16'(V_RES - 1);

    localparam logic [7:0] OP_SLPOUT = 8'h11;
    localparam logic [7:0] OP_DISPON = 8'h29;
    localparam logic [7:0] OP_CASET  = 8'h2A;
    localparam logic [7:0] OP_PASET  = 8'h2B;
    localparam logic [7:0] OP_RAMWR  = 8'h2C;
    localparam logic [7:0] OP_MADCTL = 8'h36;
    localparam logic [7:0] OP_COLMOD = 8'h3A;

    localparam logic [3:0] ST_RST_REQ  = 4'd0;
    localparam logic [3:0] ST_RST_WAIT = 4'd1;
    localparam logic [3:0] ST_SLPOUT   = 4'd2;
    localparam logic [3:0] ST_SLP_WAIT = 4'd3;
    localparam logic [3:0] ST_COLMOD   = 4'd4;
    localparam logic [3:0] ST_MADCTL   = 4'd5;
    localparam logic [3:0] ST_DISPON   = 4'd6;
    localparam logic [3:0] ST_READY    = 4'd7;
    localparam logic [3:0] ST_CASET    = 4'd8;
    localparam logic [3:0] ST_PASET    = 4'd9;
    localparam logic [3:0] ST_RAMWR    = 4'd10;

    logic [3:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [PIX_W-1:0]      pix_q, pix_d;
    logic [PXL_W-1:0]      hold_q, hold_d;
    logic                  full_q, full_d;
    logic                  vld_q, vld_d;
    logic                  hrst_q, hrst_d;
    logic [7:0]            typ_q, typ_d;
    logic [DBI_IF_D_W-1:0] dat_q, dat_d;
    logic                  nd_q, nd_d;
    logic                  last_q, last_d;
    logic                  init_q, init_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  hs, beat_end, load, pxl_rdy, pxl_take;
    logic [CNT_W-1:0]      idx;
    logic                  b_cmd, b_hrst, b_nd, b_last, b_avail;
    logic [7:0]            b_typ;
    logic [DBI_IF_D_W-1:0] b_dat;

    // Window parameter bytes: start address is always zero, end address is big-endian
    function automatic logic [7:0] win_byte(input logic [1:0] i, input logic [15:0] v);
        case (i)
            2'd2:    win_byte = v[15:8];
            2'd3:    win_byte = v[7:0];
            default: win_byte = 8'h00;
        endcase
    endfunction

    assign pxl_rdy  = (state_q == ST_RAMWR) & ~full_q & (pix_q < PIX_TOTAL);
    assign pxl_take = pxl_rdy & bus.pxl_vld_i;

    // Beat lookup: payload for the beat at index idx of the current command
    always_comb begin
        hs       = vld_q & bus.dtf_tx_rdy_i;
        beat_end = hs & (hrst_q | last_q);
        // After a mid-command handshake the next beat is the following index
        idx      = hs ? cnt_q + CNT_W'(1) : cnt_q;
        b_cmd    = 1'b0;
        b_hrst   = 1'b0;
        b_typ    = 8'h00;
        b_dat    = '0;
        b_nd     = 1'b0;
        b_last   = 1'b0;
        b_avail  = 1'b1;
        case (state_q)
            ST_RST_REQ: begin
                b_cmd  = 1'b1;
                b_hrst = 1'b1;
            end
            ST_SLPOUT: begin
                b_cmd  = 1'b1;
                b_typ  = OP_SLPOUT;
                b_nd   = 1'b1;
                b_last = 1'b1;
            end
            ST_COLMOD: begin
                b_cmd  = 1'b1;
                b_typ  = OP_COLMOD;
                b_dat  = COLMOD_VAL;
                b_last = 1'b1;
            end
            ST_MADCTL: begin
                b_cmd  = 1'b1;
                b_typ  = OP_MADCTL;
                b_dat  = MADCTL_VAL;
                b_last = 1'b1;
            end
            ST_DISPON: begin
                b_cmd  = 1'b1;
                b_typ  = OP_DISPON;
                b_nd   = 1'b1;
                b_last = 1'b1;
            end
            ST_CASET: begin
                b_cmd  = 1'b1;
                b_typ  = OP_CASET;
                b_dat  = win_byte(idx[1:0], COL_END);
                b_last = (idx[1:0] == 2'd3);
            end
            ST_PASET: begin
                b_cmd  = 1'b1;
                b_typ  = OP_PASET;
                b_dat  = win_byte(idx[1:0], ROW_END);
                b_last = (idx[1:0] == 2'd3);
            end
            ST_RAMWR: begin
                b_cmd   = 1'b1;
                b_typ   = OP_RAMWR;
                b_dat   = idx[0] ? hold_q[7:0] : hold_q[PXL_W-1 -: 8];
                b_last  = (idx == LAST_BYTE);
                // The low byte always comes from the pixel already held.
                // A high byte needs a pixel that is not being drained at this edge.
                b_avail = idx[0] | (full_q & ~hs);
            end
            default: ;
        endcase
        load = b_cmd & b_avail & (~vld_q | (hs & ~beat_end));
    end

    // Next-state: sequencing, wait timer, pixel holding register and request payload
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        pix_d   = pix_q;
        hold_d  = hold_q;
        full_d  = full_q;
        vld_d   = vld_q;
        hrst_d  = hrst_q;
        typ_d   = typ_q;
        dat_d   = dat_q;
        nd_d    = nd_q;
        last_d  = last_q;
        init_d  = init_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (load) begin
            vld_d  = 1'b1;
            hrst_d = b_hrst;
            typ_d  = b_typ;
            dat_d  = b_dat;
            nd_d   = b_nd;
            last_d = b_last;
        end else if (hs) begin
            vld_d = 1'b0;
        end

        if (hs) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (hs && state_q == ST_RAMWR && cnt_q[0]) begin
            full_d = 1'b0;
        end
        if (pxl_take) begin
            hold_d = bus.pxl_dat_i;
            full_d = 1'b1;
            pix_d  = pix_q + PIX_W'(1);
        end

        case (state_q)
            ST_RST_REQ: if (beat_end) begin
                state_d = ST_RST_WAIT;
                wait_d  = RST_LOAD;
            end
            ST_RST_WAIT: begin
                if (wait_q == '0) state_d = ST_SLPOUT;
                else              wait_d  = wait_q - WAIT_W'(1);
            end
            ST_SLPOUT: if (beat_end) begin
                state_d = ST_SLP_WAIT;
                wait_d  = SLP_LOAD;
            end
            ST_SLP_WAIT: begin
                if (wait_q == '0) state_d = ST_COLMOD;
                else              wait_d  = wait_q - WAIT_W'(1);
            end
            ST_COLMOD: if (beat_end) state_d = ST_MADCTL;
            ST_MADCTL: if (beat_end) state_d = ST_DISPON;
            ST_DISPON: if (beat_end) begin
                state_d = ST_READY;
                init_d  = 1'b1;
            end
            ST_READY: if (frm_start_i) begin
                state_d = ST_CASET;
                busy_d  = 1'b1;
            end
            ST_CASET: if (beat_end) state_d = ST_PASET;
            ST_PASET: if (beat_end) begin
                state_d = ST_RAMWR;
                pix_d   = '0;
            end
            ST_RAMWR: if (beat_end) begin
                state_d = ST_READY;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = ST_RST_REQ;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // State and registered outputs; reset aborts everything and restarts init
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RST_REQ;
            cnt_q   <= '0;
            wait_q  <= '0;
            pix_q   <= '0;
            hold_q  <= '0;
            full_q  <= 1'b0;
            vld_q   <= 1'b0;
            hrst_q  <= 1'b0;
            typ_q   <= 8'h00;
            dat_q   <= '0;
            nd_q    <= 1'b0;
            last_q  <= 1'b0;
            init_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            pix_q   <= pix_d;
            hold_q  <= hold_d;
            full_q  <= full_d;
            vld_q   <= vld_d;
            hrst_q  <= hrst_d;
            typ_q   <= typ_d;
            dat_q   <= dat_d;
            nd_q    <= nd_d;
            last_q  <= last_d;
            init_q  <= init_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.pxl_rdy_o        = pxl_rdy;
    assign bus.dtf_dbi_hrst_o   = hrst_q;
    assign bus.dtf_tx_cmd_typ_o = typ_q;
    assign bus.dtf_tx_cmd_dat_o = dat_q;
    assign bus.dtf_tx_no_dat_o  = nd_q;
    assign bus.dtf_tx_last_o    = last_q;
    assign bus.dtf_tx_vld_o     = vld_q;
    assign init_done_o          = init_q;
    assign frm_busy_o           = busy_q;
    assign frm_done_o           = done_q;

endmodule

// File: tb/tb_dbi_tx_fsm.sv
// Directed bench for dbi_tx_fsm.
// Configuration: 2x2 frame, 4-cycle init waits.
module tb_dbi_tx_fsm;

    logic clk;
    logic rst;
    logic frm_start;
    logic init_done, frm_busy, frm_done;

    dbi_tx_fsm_if bus ();

    dbi_tx_fsm #(
        .H_RES          (2),
        .V_RES          (2),
        .T_RST_WAIT_CYC (4),
        .T_SLP_WAIT_CYC (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frm_start_i (frm_start),
        .bus         (bus),
        .init_done_o (init_done),
        .frm_busy_o  (frm_busy),
        .frm_done_o  (frm_done)
    );

    int vectors = 0;
    int miscompares = 0;

    // Beat record: {hrst, no_dat, last, cmd_typ, cmd_dat}
    logic [18:0] log_q[$];
    int          log_cyc[$];
    int          cyc = 0;
    int          init_rise_cyc = -1;
    int          done_cnt = 0;
    int          stab_err = 0;
    int          stall_cnt = 0;
    logic        prev_stall = 1'b0;
    logic        prev_init = 1'b0;
    logic [18:0] prev_beat = '0;

    logic [15:0] pix [4];
    logic [15:0] set_a [4];
    logic [15:0] set_b [4];
    logic [15:0] set_c [4];
    int          pix_idx = 0;
    int          gap_at = -1;
    int          gap_cnt = 0;
    bit          src_en = 1'b0;
    bit          bp = 1'b0;

    wire [18:0] cur_beat = {bus.dtf_dbi_hrst_o, bus.dtf_tx_no_dat_o, bus.dtf_tx_last_o,
                            bus.dtf_tx_cmd_typ_o, bus.dtf_tx_cmd_dat_o};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // Passive monitor: beat log, stall stability, init_done rise, done pulses
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_stall = 1'b0;
                prev_init  = 1'b0;
            end else begin
                if (prev_stall && (!bus.dtf_tx_vld_o || cur_beat !== prev_beat)) stab_err++;
                if (bus.dtf_tx_vld_o && bus.dtf_tx_rdy_i) begin
                    log_q.push_back(cur_beat);
                    log_cyc.push_back(cyc);
                end
                prev_stall = bus.dtf_tx_vld_o && !bus.dtf_tx_rdy_i;
                if (prev_stall) stall_cnt++;
                prev_beat = cur_beat;
                if (init_done && !prev_init) init_rise_cyc = cyc;
                prev_init = init_done;
                if (frm_done) done_cnt++;
            end
        end
    end

    function automatic logic [18:0] mk(input logic h, input logic nd, input logic l,
                                       input logic [7:0] t, input logic [7:0] d);
        return {h, nd, l, t, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: sample pixel handshake at negedge, update drivers 1 unit after posedge
    task automatic tick();
        bit take;
        @(negedge clk);
        take = bus.pxl_vld_i && bus.pxl_rdy_o;
        @(posedge clk);
        #1;
        if (take) begin
            pix_idx++;
            if (pix_idx == gap_at) gap_cnt = 10;
        end
        if (gap_cnt > 0) begin
            bus.pxl_vld_i = 1'b0;
            gap_cnt--;
        end else begin
            bus.pxl_vld_i = src_en && (pix_idx < 4);
        end
        bus.pxl_dat_i = (pix_idx < 4) ? pix[pix_idx] : 16'h0000;
        bus.dtf_tx_rdy_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_vld"},       bus.dtf_tx_vld_o,     0);
        chk({tag, "_hrst"},      bus.dtf_dbi_hrst_o,   0);
        chk({tag, "_typ"},       bus.dtf_tx_cmd_typ_o, 0);
        chk({tag, "_dat"},       bus.dtf_tx_cmd_dat_o, 0);
        chk({tag, "_no_dat"},    bus.dtf_tx_no_dat_o,  0);
        chk({tag, "_last"},      bus.dtf_tx_last_o,    0);
        chk({tag, "_pxl_rdy"},   bus.pxl_rdy_o,        0);
        chk({tag, "_init_done"}, init_done,            0);
        chk({tag, "_busy"},      frm_busy,             0);
        chk({tag, "_done"},      frm_done,             0);
    endtask

    task automatic wait_init(input string tag);
        for (int i = 0; i < 200 && !init_done; i++) tick();
        chk({tag, "_init_done"}, init_done, 1);
    endtask

    task automatic run_frame(input logic [15:0] p [4], input bit use_bp, input int gap_pix,
                             input bit ign, input string tag);
        int          base;
        int          done0;
        bit          pulsed;
        bit          fin;
        bit          busy_seen;
        int          stab0;
        logic [18:0] exp [16];
        base      = log_q.size();
        done0     = done_cnt;
        stab0     = stab_err;
        pulsed    = 1'b0;
        fin       = 1'b0;
        busy_seen = 1'b0;
        pix       = p;
        pix_idx   = 0;
        gap_at    = gap_pix;
        gap_cnt   = 0;
        src_en    = 1'b1;
        bp        = use_bp;
        frm_start = 1'b1;
        tick();
        frm_start = 1'b0;
        for (int i = 0; i < 400 && !fin; i++) begin
            if (ign && !pulsed && log_q.size() >= base + 9) begin
                frm_start = 1'b1;
                pulsed    = 1'b1;
            end
            tick();
            frm_start = 1'b0;
            if (gap_cnt >= 1 && gap_cnt <= 5) chk({tag, "_vld_low_in_gap"}, bus.dtf_tx_vld_o, 0);
            if (frm_busy) busy_seen = 1'b1;
            if (done_cnt != done0) fin = 1'b1;
        end
        bp     = 1'b0;
        src_en = 1'b0;
        repeat (20) tick();
        chk({tag, "_busy_seen"}, busy_seen, 1);
        chk({tag, "_done_pulses"}, done_cnt - done0, 1);
        chk({tag, "_beat_count"}, log_q.size() - base, 16);
        chk({tag, "_busy_after"}, frm_busy, 0);
        if (use_bp) begin
            chk({tag, "_stable_under_stall"}, stab_err - stab0, 0);
            chk({tag, "_stalls_exercised"}, stall_cnt != 0, 1);
        end
        for (int k = 0; k < 4; k++) begin
            exp[k]     = mk(1'b0, 1'b0, k == 3, 8'h2A, (k == 3) ? 8'h01 : 8'h00);
            exp[k + 4] = mk(1'b0, 1'b0, k == 3, 8'h2B, (k == 3) ? 8'h01 : 8'h00);
            exp[8 + 2 * k]     = mk(1'b0, 1'b0, 1'b0, 8'h2C, p[k][15:8]);
            exp[8 + 2 * k + 1] = mk(1'b0, 1'b0, k == 3, 8'h2C, p[k][7:0]);
        end
        for (int k = 0; k < 16; k++) begin
            if (base + k < log_q.size())
                chk($sformatf("%s_beat%0d", tag, k), log_q[base + k], exp[k]);
        end
    endtask

    initial begin
        int base;
        set_a = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        set_b = '{16'hA5C3, 16'h0FF0, 16'h8001, 16'h7E42};
        set_c = '{16'h1357, 16'h2468, 16'hFEDC, 16'h0B0A};
        pix = set_a;
        rst = 1'b1;
        frm_start = 1'b0;
        bus.pxl_vld_i = 1'b0;
        bus.pxl_dat_i = 16'h0000;
        bus.dtf_tx_rdy_i = 1'b1;

        // Reset values, then a start pulse while still in reset
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        frm_start = 1'b1;
        tick();
        frm_start = 1'b0;

        // Init sequence with a stray start pulse during the waits
        rst = 1'b0;
        tick();
        chk("first_vld_after_release", bus.dtf_tx_vld_o, 1);
        chk("first_beat_hrst", bus.dtf_dbi_hrst_o, 1);
        for (int i = 0; i < 200 && !init_done; i++) begin
            if (i == 8) frm_start = 1'b1;
            tick();
            frm_start = 1'b0;
        end
        repeat (10) tick();
        chk("init_beat_count", log_q.size(), 5);
        if (log_q.size() >= 5) begin
            chk("init_hrst",   log_q[0][18], 1);
            chk("init_slpout", log_q[1][18:8], {1'b0, 1'b1, 1'b1, 8'h11});
            chk("init_colmod", log_q[2], mk(1'b0, 1'b0, 1'b1, 8'h3A, 8'h55));
            chk("init_madctl", log_q[3], mk(1'b0, 1'b0, 1'b1, 8'h36, 8'h00));
            chk("init_dispon", log_q[4][18:8], {1'b0, 1'b1, 1'b1, 8'h29});
            chk("gap_after_hrst",   log_cyc[1] - log_cyc[0], 6);
            chk("gap_after_slpout", log_cyc[2] - log_cyc[1], 6);
            chk("init_done_rise",   init_rise_cyc, log_cyc[4] + 1);
        end

        // Plain frame with an ignored start pulse during RAMWR
        run_frame(set_a, 1'b0, -1, 1'b1, "frm_plain");
        // Random PHY backpressure across the whole frame
        run_frame(set_b, 1'b1, -1, 1'b0, "frm_bp");
        // Pixel source drops out for 10 cycles after the second pixel
        run_frame(set_a, 1'b0, 2, 1'b0, "frm_gap");

        // Reset after the third RAMWR byte
        base = log_q.size();
        pix = set_c;
        pix_idx = 0;
        gap_at = -1;
        src_en = 1'b1;
        frm_start = 1'b1;
        tick();
        frm_start = 1'b0;
        for (int i = 0; i < 200 && log_q.size() < base + 11; i++) tick();
        chk("pre_reset_bytes", log_q.size() - base, 11);
        #2 rst = 1'b1;
        #1;
        chk_outputs_zero("mid_reset");
        src_en = 1'b0;
        tick();
        rst = 1'b0;
        base = log_q.size();
        for (int i = 0; i < 20 && log_q.size() == base; i++) tick();
        chk("post_reset_beat_seen", log_q.size() > base, 1);
        if (log_q.size() > base) chk("post_reset_hrst", log_q[base][18], 1);
        chk("post_reset_init_low", init_done, 0);
        wait_init("reinit");
        run_frame(set_c, 1'b0, -1, 1'b0, "frm_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
